// File: rtl/dbus_if.sv
// System data bus: single outstanding valid/ready transfer with byte strobes.
// The bridge drives the request side (master); the memory/peripheral answers (slave).
interface dbus_if #(
  parameter int XLEN = 32
) ();
  logic              bus_valid;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wstrb;
  logic              bus_we;
  logic              bus_ready;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  modport master (
    output bus_valid, bus_addr, bus_wdata, bus_wstrb, bus_we,
    input  bus_ready, bus_rdata, bus_err
  );

  modport slave (
    input  bus_valid, bus_addr, bus_wdata, bus_wstrb, bus_we,
    output bus_ready, bus_rdata, bus_err
  );
endinterface

// File: rtl/dbus_bridge.sv
// CPU data-port to system-bus bridge: converts a held CPU request into one bus
// transfer, stalls the core until it completes, and aborts after TIMEOUT cycles.
module dbus_bridge #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_din,
  input  logic [XLEN/8-1:0] mem_w,
  input  logic              mem_r,
  output logic [XLEN-1:0]   mem_dout,
  output logic              stall,
  output logic              err,
  dbus_if.master            bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   data_q;
  logic              err_q;
  logic              req;

  // Any strobe bit makes the access a write, so mem_r is irrelevant then.
  assign req = mem_r | (|mem_w);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      data_q        <= '0;
      err_q         <= 1'b0;
      bus.bus_valid <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wstrb <= '0;
      bus.bus_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            bus.bus_addr  <= mem_addr;
            bus.bus_wdata <= mem_din;
            bus.bus_wstrb <= mem_w;
            bus.bus_we    <= |mem_w;
            bus.bus_valid <= 1'b1;
            cnt           <= '0;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ready) begin
            data_q        <= bus.bus_we ? '0 : bus.bus_rdata;
            err_q         <= bus.bus_err;
            bus.bus_valid <= 1'b0;
            state         <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Dead slave: abandon the transfer and report it as an error.
            data_q        <= '0;
            err_q         <= 1'b1;
            bus.bus_valid <= 1'b0;
            state         <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // rstn gates stall so a held request cannot freeze the core during reset.
  assign stall    = rstn && ((state == IDLE && req) || state == REQ);
  assign err      = (state == DONE) && err_q;
  assign mem_dout = data_q;

endmodule
